// File: rtl/alu_multicycle_pkg.sv
// ---------------------------------------------------------------------------
// alu_multicycle_pkg
//   Shared opcode header for the ALU family, plus the state encoding of the
//   multicycle ALU controller.
//   Contents:
//     opcode_e   : 5-bit opcode set. DIV and MOD occupy codes that the
//                  combinational ALU left unused.
//     state_e    : IDLE / ITER / DONE controller states.
//     is_iter_op : true for the opcodes served by the iterative engine.
// ---------------------------------------------------------------------------
package alu_multicycle_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_INC  = 5'd3,
        OP_DEC  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_XOR  = 5'd7,
        OP_NOT  = 5'd8,
        OP_NAND = 5'd9,
        OP_NOR  = 5'd10,
        OP_NXOR = 5'd11,
        OP_LSH  = 5'd12,
        OP_ALSH = 5'd13,
        OP_RSH  = 5'd14,
        OP_ARSH = 5'd15,
        OP_ROTL = 5'd16,
        OP_ROTR = 5'd17,
        OP_MUL  = 5'd18,
        OP_DIV  = 5'd19,
        OP_MOD  = 5'd20
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
//   Shared unsigned iterative engine: WIDTH-step shift-add multiply or
//   restoring divide on operand magnitudes. Signs are handled by the caller.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     flush_i     : abandon the current operation (counter cleared)
//     start_i     : load magnitudes and start a WIDTH-step run
//     is_div_i    : 1 = restoring divide, 0 = shift-add multiply
//     a_mag_i     : |a| (multiplier / dividend)
//     b_mag_i     : |b| (multiplicand / divisor)
//     cnt_o       : remaining steps; 1 means the step in progress is the last
//     hi_d_o      : next high half (product high / remainder)
//     lo_d_o      : next low half  (product low  / quotient)
//   The caller samples hi_d_o/lo_d_o while cnt_o==1 so the final step and the
//   sign fix-up land on the same edge.
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH-1:0] b_mag_i,
    output logic [CW-1:0]    cnt_o,
    output logic [WIDTH-1:0] hi_d_o,
    output logic [WIDTH-1:0] lo_d_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mb_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_w;
    logic [WIDTH:0]   sum_w;
    logic             q_bit;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        rem_w = '0;
        sum_w = '0;
        q_bit = 1'b0;
        if (div_q) begin
            // Shift the next dividend bit into the partial remainder and
            // subtract the divisor when it fits.
            rem_w = {hi_q, lo_q[WIDTH-1]};
            if (rem_w >= {1'b0, mb_q}) begin
                rem_w = rem_w - {1'b0, mb_q};
                q_bit = 1'b1;
            end
            hi_d = rem_w[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], q_bit};
        end else begin
            // Add the multiplicand when the multiplier LSB is set, then shift
            // the whole {hi, lo} pair right by one.
            sum_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
            hi_d  = sum_w[WIDTH:1];
            lo_d  = {sum_w[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            mb_q  <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            hi_q  <= '0;
            lo_q  <= a_mag_i;
            mb_q  <= b_mag_i;
            div_q <= is_div_i;
            cnt_q <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign hi_d_o = hi_d;
    assign lo_d_o = lo_d;

endmodule

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Registered ALU with valid/ready handshakes. Logic, shift, rotate and
//   add/sub ops complete in one cycle; signed MUL/DIV/MOD run WIDTH steps on
//   the shared alu_muldiv_iter engine, followed by sign fix-up here.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     flush               : synchronous abort, back to IDLE, nothing delivered
//     in_valid / in_ready : operand handshake (accept on both high at an edge)
//     opcode              : 5-bit opcode (alu_multicycle_pkg::opcode_e)
//     data_a, data_b      : signed operands, captured at accept
//     out_valid/out_ready : result handshake
//     result              : WIDTH-bit result
//     overflow, error,
//     zero, negative      : flags qualified by out_valid
// ---------------------------------------------------------------------------
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              opcode,
    input  logic signed [WIDTH-1:0] data_a,
    input  logic signed [WIDTH-1:0] data_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    overflow,
    output logic                    error,
    output logic                    zero,
    output logic                    negative
);

    localparam int CW = SHW + 1;
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_V = ~MIN_V;

    state_e                  state_q;
    logic [4:0]              op_q;
    logic signed [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0]        result_q;
    logic                    ovf_q, err_q, zero_q, neg_q;

    logic accept;

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Single-cycle datapath, driven straight from the input operands.
    logic [SHW-1:0]       sh_amt;
    logic                 sh_big;
    logic [2*WIDTH-1:0]   rot_l, rot_r;
    logic [WIDTH-1:0]     sum_w;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_ovf, sc_err;

    assign sh_amt = data_b[SHW-1:0];
    assign sh_big = |data_b[WIDTH-1:SHW];
    // Rotating the doubled word keeps the rotate-by-0 case free of a WIDTH shift.
    assign rot_l  = {data_a, data_a} << sh_amt;
    assign rot_r  = {data_a, data_a} >> sh_amt;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_err = 1'b0;
        sum_w  = '0;
        case (opcode)
            OP_NOP:  ;
            OP_ADD: begin
                sum_w  = data_a + data_b;
                sc_res = sum_w;
                sc_ovf = (data_a[WIDTH-1] == data_b[WIDTH-1]) && (sum_w[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_SUB: begin
                sum_w  = data_a - data_b;
                sc_res = sum_w;
                sc_ovf = (data_a[WIDTH-1] != data_b[WIDTH-1]) && (sum_w[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_INC: begin
                sc_res = $unsigned(data_a) + WIDTH'(1);
                sc_ovf = ($unsigned(data_a) == MAX_V);
            end
            OP_DEC: begin
                sc_res = $unsigned(data_a) - WIDTH'(1);
                sc_ovf = ($unsigned(data_a) == MIN_V);
            end
            OP_AND:  sc_res = data_a & data_b;
            OP_OR:   sc_res = data_a | data_b;
            OP_XOR:  sc_res = data_a ^ data_b;
            OP_NOT:  sc_res = ~data_a;
            OP_NAND: sc_res = ~(data_a & data_b);
            OP_NOR:  sc_res = ~(data_a | data_b);
            OP_NXOR: sc_res = ~(data_a ^ data_b);
            OP_LSH, OP_ALSH: sc_res = sh_big ? '0 : ($unsigned(data_a) << sh_amt);
            OP_RSH:  sc_res = sh_big ? '0 : ($unsigned(data_a) >> sh_amt);
            OP_ARSH: sc_res = sh_big ? {WIDTH{data_a[WIDTH-1]}} : $unsigned(data_a >>> sh_amt);
            OP_ROTL: sc_res = rot_l[2*WIDTH-1:WIDTH];
            OP_ROTR: sc_res = rot_r[WIDTH-1:0];
            OP_MUL, OP_DIV, OP_MOD: ;
            default: sc_err = 1'b1;
        endcase
    end

    // Iterative engine on operand magnitudes.
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [CW-1:0]    it_cnt;
    logic [WIDTH-1:0] it_hi_d, it_lo_d;

    assign a_mag = data_a[WIDTH-1] ? -$unsigned(data_a) : $unsigned(data_a);
    assign b_mag = data_b[WIDTH-1] ? -$unsigned(data_b) : $unsigned(data_b);

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush),
        .start_i  (accept && is_iter_op(opcode)),
        .is_div_i (opcode != OP_MUL),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .cnt_o    (it_cnt),
        .hi_d_o   (it_hi_d),
        .lo_d_o   (it_lo_d)
    );

    // Sign fix-up of the final engine step.
    logic [2*WIDTH-1:0] prod_mag, prod_s;
    logic               res_neg;
    logic [WIDTH-1:0]   fx_res;
    logic               fx_ovf, fx_err;

    assign prod_mag = {it_hi_d, it_lo_d};
    assign res_neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];

    always_comb begin
        fx_res = '0;
        fx_ovf = 1'b0;
        fx_err = 1'b0;
        prod_s = '0;
        case (op_q)
            OP_MUL: begin
                prod_s = res_neg ? -prod_mag : prod_mag;
                fx_res = prod_s[WIDTH-1:0];
                fx_ovf = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    fx_res = '1;
                    fx_err = 1'b1;
                end else if (($unsigned(a_q) == MIN_V) && (b_q == '1)) begin
                    fx_res = MIN_V;
                    fx_ovf = 1'b1;
                end else begin
                    fx_res = res_neg ? -it_lo_d : it_lo_d;
                end
            end
            OP_MOD: begin
                // MIN % -1 falls out as a zero remainder on its own.
                if (b_q == '0) begin
                    fx_res = a_q;
                    fx_err = 1'b1;
                end else begin
                    fx_res = a_q[WIDTH-1] ? -it_hi_d : it_hi_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else if (accept) begin
            op_q <= opcode;
            a_q  <= data_a;
            b_q  <= data_b;
            if (is_iter_op(opcode)) begin
                state_q <= ST_ITER;
            end else begin
                state_q  <= ST_DONE;
                result_q <= sc_res;
                ovf_q    <= sc_ovf;
                err_q    <= sc_err;
                zero_q   <= (sc_res == '0);
                neg_q    <= sc_res[WIDTH-1];
            end
        end else begin
            case (state_q)
                ST_ITER: begin
                    if (it_cnt == CW'(1)) begin
                        state_q  <= ST_DONE;
                        result_q <= fx_res;
                        ovf_q    <= fx_ovf;
                        err_q    <= fx_err;
                        zero_q   <= (fx_res == '0);
                        neg_q    <= fx_res[WIDTH-1];
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign error     = err_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
//   Directed and randomized checks of alu_multicycle at WIDTH=32 against an
//   arithmetic reference model built on 64-bit integers.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  opcode = 5'd0;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, error, zero, negative;

    int ntests = 0;
    int nfail  = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .error     (error),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain 64-bit signed arithmetic.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov, output logic er);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ub = longint'(b);
        longint full;
        r = '0; ov = 1'b0; er = 1'b0; full = 0;
        case (op)
            OP_NOP: ;
            OP_ADD: full = sa + sb;
            OP_SUB: full = sa - sb;
            OP_INC: full = sa + 1;
            OP_DEC: full = sa - 1;
            OP_MUL: full = sa * sb;
            OP_DIV: full = (sb == 0) ? -1 : sa / sb;
            OP_MOD: full = (sb == 0) ? sa : sa % sb;
            default: ;
        endcase
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_MUL, OP_DIV: begin
                r  = full[31:0];
                ov = (full != longint'($signed(r)));
            end
            OP_MOD: r = full[31:0];
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_NXOR: r = ~(a ^ b);
            OP_LSH, OP_ALSH: r = (ub >= 32) ? 32'd0 : (a << ub);
            OP_RSH:  r = (ub >= 32) ? 32'd0 : (a >> ub);
            OP_ARSH: begin
                full = sa >>> ((ub >= 32) ? 63 : ub);
                r = full[31:0];
            end
            OP_ROTL: begin
                r = a;
                for (int k = 0; k < int'(b[4:0]); k++) r = {r[30:0], r[31]};
            end
            OP_ROTR: begin
                r = a;
                for (int k = 0; k < int'(b[4:0]); k++) r = {r[0], r[31:1]};
            end
            OP_NOP: ;
            default: er = 1'b1;
        endcase
        if ((op == OP_DIV || op == OP_MOD) && b == 0) er = 1'b1;
    endfunction

    // Issue one op from IDLE, wait for the result and compare everything.
    // With consume=0 the result is left pending with out_ready low.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_o, input logic exp_e, input bit consume);
        int cyc;
        int exp_lat;
        exp_lat = (op == OP_MUL || op == OP_DIV || op == OP_MOD) ? 33 : 1;
        opcode = op; data_a = a; data_b = b; in_valid = 1'b1; out_ready = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 100) begin step(); cyc++; end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        opcode = 5'($urandom); data_a = $urandom; data_b = $urandom;
        cyc = 1;
        while (!out_valid && cyc < 100) begin step(); cyc++; end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, result, exp_r);
        check({tag, " overflow"}, 32'(overflow), 32'(exp_o));
        check({tag, " error"}, 32'(error), 32'(exp_e));
        check({tag, " zero"}, 32'(zero), 32'(exp_r == 32'd0));
        check({tag, " negative"}, 32'(negative), 32'(exp_r[31]));
        if (consume) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check({tag, " drained"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic run_rand(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic ov, er;
        model(op, a, b, r, ov, er);
        run_op(tag, op, a, b, r, ov, er, 1'b1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return 32'd1;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] sa_tab [4] = '{32'hF0F0F0F0, 32'h12345678, 32'hFFFFFFFF, 32'h0000FFFF};
    logic [31:0] sb_tab [4] = '{32'hFF00FF00, 32'h0F0F0F0F, 32'h80000001, 32'hFFFF0000};

    initial begin
        int cyc;
        logic [4:0] rop;

        // Reset
        #2 rst = 1'b1;
        step(); step();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {28'd0, overflow, error, zero, negative}, 32'd0);
        rst = 1'b0;
        step();

        // Directed cases
        run_op("add_ovf",   OP_ADD,  32'h7FFFFFFF, 32'd1,         32'h80000000, 1'b1, 1'b0, 1'b1);
        run_op("mul_neg",   OP_MUL,  32'hFFFFFFFD, 32'd7,         32'hFFFFFFEB, 1'b0, 1'b0, 1'b1);
        run_op("mul_ovf",   OP_MUL,  32'h00010000, 32'h00010000,  32'h00000000, 1'b1, 1'b0, 1'b1);
        run_op("div_neg",   OP_DIV,  32'hFFFFFFF9, 32'd2,         32'hFFFFFFFD, 1'b0, 1'b0, 1'b1);
        run_op("mod_neg",   OP_MOD,  32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        run_op("div_zero",  OP_DIV,  32'd5,        32'd0,         32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
        run_op("mod_zero",  OP_MOD,  32'd5,        32'd0,         32'd5,        1'b0, 1'b1, 1'b1);
        run_op("div_min",   OP_DIV,  32'h80000000, 32'hFFFFFFFF,  32'h80000000, 1'b1, 1'b0, 1'b1);
        run_op("mod_min",   OP_MOD,  32'h80000000, 32'hFFFFFFFF,  32'h00000000, 1'b0, 1'b0, 1'b1);
        run_op("arsh_big",  OP_ARSH, 32'h80000000, 32'd40,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        run_op("lsh_big",   OP_LSH,  32'd1,        32'd32,        32'd0,        1'b0, 1'b0, 1'b1);
        run_op("rsh_31",    OP_RSH,  32'h80000000, 32'd31,        32'd1,        1'b0, 1'b0, 1'b1);
        run_op("rotl_1",    OP_ROTL, 32'h80000001, 32'd1,         32'd3,        1'b0, 1'b0, 1'b1);
        run_op("rotr_0",    OP_ROTR, 32'h80000001, 32'd0,         32'h80000001, 1'b0, 1'b0, 1'b1);
        run_op("inc_max",   OP_INC,  32'h7FFFFFFF, 32'd0,         32'h80000000, 1'b1, 1'b0, 1'b1);
        run_op("dec_min",   OP_DEC,  32'h80000000, 32'd0,         32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
        run_op("nop",       OP_NOP,  32'd5,        32'd3,         32'd0,        1'b0, 1'b0, 1'b1);
        run_op("unknown",   5'd31,   32'd5,        32'd3,         32'd0,        1'b0, 1'b1, 1'b1);

        // Stall in DONE, then stream four ANDs back to back
        run_op("sub_hold", OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0);
        opcode = OP_AND; data_a = sa_tab[0]; data_b = sb_tab[0]; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold%0d result", k), result, 32'd7);
            check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("stream%0d valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stream%0d result", k), result, sa_tab[k] & sb_tab[k]);
            if (k < 3) begin
                data_a = sa_tab[k+1]; data_b = sb_tab[k+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        step();
        out_ready = 1'b0;
        check("stream drained", 32'(out_valid), 32'd0);

        // Flush mid-iteration: nothing delivered
        opcode = OP_DIV; data_a = 32'd100; data_b = 32'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 40) begin step(); cyc++; end
        check("flush no result", 32'(out_valid), 32'd0);

        // Flush coincident with an accept: op rejected
        opcode = OP_ADD; data_a = 32'd1; data_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_acc out_valid", 32'(out_valid), 32'd0);
        step();
        check("flush_acc later", 32'(out_valid), 32'd0);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, 20));
            run_rand($sformatf("rnd%0d op%0d", i, rop), rop, pick(), pick());
        end

        // Reset at iteration 10 of a DIV
        run_op("pre_rst", OP_ADD, 32'h1234, 32'd1, 32'h1235, 1'b0, 1'b0, 1'b1);
        opcode = OP_DIV; data_a = 32'd1000; data_b = 32'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        #1;
        check("rst_iter in_ready", 32'(in_ready), 32'd1);
        check("rst_iter out_valid", 32'(out_valid), 32'd0);
        check("rst_iter result", result, 32'd0);
        check("rst_iter flags", {28'd0, overflow, error, zero, negative}, 32'd0);
        step();
        rst = 1'b0;
        step();
        run_op("post_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

- Parametrised, registered successor to the PIGRO combinational ALU.
- Adds a valid/ready handshake on both sides, a generic datapath width, and iterative signed MUL/DIV/MOD with a shared shift-add/restoring engine.
- Adds signed overflow, divide-by-zero and zero/negative flags.
- Sits between the register-file read stage and write-back; the control unit stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32: datapath width; ≥ 8, power of two.
- `SHW`, $clog2(WIDTH): shift/rotate amount bits, derived; do not override.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high. This is fixed (already decided).
- `flush` in 1: synchronous abort of any operation in flight; returns to IDLE next edge.
- `in_valid` in 1: operands/opcode valid.
- `in_ready` out 1: block accepts on `in_valid & in_ready` at a rising edge.
- `opcode` in 5: shared opcode set plus `DIV`, `MOD`.
- `data_a`, `data_b` in WIDTH: signed operands.
- `out_valid` out 1: result/flags valid.
- `out_ready` in 1: consumer takes the result on `out_valid & out_ready`.
- `result` out WIDTH: result.
- `overflow`, `error`, `zero`, `negative` out 1 each: flags qualified by `out_valid`.

## Operation
- **States:** IDLE, ITER, DONE.
  - IDLE: `in_ready`=1.
  - Accept of a single-cycle op → DONE.
  - Accept of MUL/DIV/MOD → ITER with `cnt`=WIDTH.
- **ITER:** one iteration per cycle on magnitudes `|a|`, `|b|`; `cnt` decrements.
  - At `cnt`==1, sign fix-up and flags are applied in the same edge; → DONE.
- **DONE:** `out_valid`=1; `result` and flags held stable until handshake.
  - `out_ready`=1 with `in_valid`=0 → IDLE.
  - `out_ready`=1 with `in_valid`=1 → new op accepted the same edge (`in_ready` = IDLE | (DONE & `out_ready`)).
- **flush:** takes priority over everything except `rst`. → IDLE; `out_valid` drops; no result is delivered.
- **Single-cycle ops:**
  - NOT/AND/OR/XOR/NAND/NOR/NXOR: bitwise, as in the existing opcode set.
  - LSH/ALSH: `a << b`. RSH: logical. ARSH: sign-fill.
  - Shift amount ≥ WIDTH: LSH/ALSH/RSH → 0; ARSH → all sign bits.
  - ROTL/ROTR: rotate by `b[SHW-1:0]`. A rotate by 0 returns `a`.
  - INC/DEC/ADD/SUB: WIDTH-bit wrap. `overflow` is set on signed overflow, e.g. INC of MAX, DEC of MIN.
  - NOP: result 0, all flags 0.
- **MUL:** low WIDTH bits of the signed product. `overflow`=1 when the 2·WIDTH product does not sign-extend from bit WIDTH-1.
- **DIV/MOD:**
  - Signed, quotient truncates toward zero; remainder takes the dividend's sign.
  - `b`==0: `error`=1; DIV → all ones; MOD → `a`; iteration still runs the full latency.
  - MIN / -1: DIV → MIN with `overflow`=1; MOD → 0.
- **Unknown opcode:** → DONE with result 0, `error`=1.
- `zero` = (`result`==0); `negative` = `result[WIDTH-1]`. Both are valid for every op, including error cases.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `in_ready` 1, `out_valid` 0, `result` 0, all flags 0.
- **Single-cycle op:** accepted at edge N → `out_valid` high after edge N+1.
- **MUL/DIV/MOD:** accepted at edge N → `out_valid` high after edge N+WIDTH+1 (33 cycles at WIDTH=32).
- **Throughput:** back-to-back single-cycle ops reach 1 per cycle when `out_ready` is held high.
- Operands are captured at accept; later changes to `data_a`/`data_b`/`opcode` have no effect.
- **`rst` mid-ITER:** immediate return to reset values; the operation is lost.
- `flush` and accept in the same cycle: flush wins; the op is not accepted.

## Structure
- The shared opcode header gains `DIV` and `MOD` at currently unused 5-bit codes.
- State encodings (IDLE=2'd0, ITER=2'd1, DONE=2'd2) live in the same shared header.
- Sub-module `alu_muldiv_iter`: holds the magnitude registers, the WIDTH-step shift-add / restoring-subtract loop and `cnt`.
- The top level keeps the FSM, the single-cycle datapath, the sign fix-up and the flags.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1 → `result` 0x80000000, `overflow`=1, `negative`=1, `out_valid` one cycle after accept.
- MUL -3 × 7 → `result` 0xFFFFFFEB, `overflow`=0, after 33 cycles; MUL 0x10000 × 0x10000 → `result` 0, `overflow`=1, `zero`=1.
- DIV -7/2 → -3 and MOD -7/2 → -1; DIV 5/0 → 0xFFFFFFFF, `error`=1; DIV 0x80000000 / -1 → 0x80000000, `overflow`=1.
- Hold `out_ready`=0 for 5 cycles in DONE → `result` stable and `in_ready`=0; then stream 4 back-to-back ANDs with `out_ready`=1 → 4 results on 4 consecutive cycles.
- Assert `rst` at ITER cycle 10 of a DIV → all outputs return to reset values immediately; a following ADD 2+3 → 5.
- ARSH 0x80000000 by 40 → 0xFFFFFFFF; ROTL 0x80000001 by 1 → 0x00000003; unknown opcode → `result` 0, `error`=1.
